sha_nonce_scheduler: RTL and testbench

Scheduler for the bitcoin hash datapath. It hands out nonces 0..NONCE_TOTAL-1 to NUM_CORES parallel double-SHA256 hash cores over a start/done handshake. It collects each core's final h0 word and arbitrates the single memory write port so that every result lands at output_addr + nonce. It sits between the top-level start/done control and the replicated hash cores, and it owns mem_we, mem_addr and mem_write_data during the write phase.

---
 rtl/sha_nonce_scheduler.sv | 164 ++++++++++++++++
 tb/tb_sha_nonce_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_nonce_scheduler.sv
// Nonce scheduler: dispatches nonces to parallel hash cores and serialises their h0 results onto one write port.
// Build option NONCE_SCHED_RR_EN selects round-robin write arbitration; otherwise lowest pending core wins.
module sha_nonce_scheduler #(
  parameter int NUM_CORES   = 4,
  parameter int NONCE_TOTAL = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [15:0]            output_addr,
  output logic                   done,
  output logic                   busy,
  output logic [NUM_CORES-1:0]   core_start,
  output logic [31:0]            core_nonce,
  input  logic [NUM_CORES-1:0]   core_done,
  input  logic [32*NUM_CORES-1:0] core_h0,
  output logic                   mem_we,
  output logic [15:0]            mem_addr,
  output logic [31:0]            mem_write_data
);

  // state  | meaning
  // IDLE   | waiting for start
  // RUN    | dispatching nonces, collecting and writing results
  // FINISH | one-cycle done pulse, then back to IDLE
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [15:0] TOTAL = 16'(NONCE_TOTAL);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t                state;
  logic [15:0]           next_nonce;
  logic [15:0]           written_cnt;
  logic [NUM_CORES-1:0]  core_busy;
  logic [NUM_CORES-1:0]  pending;
  logic [15:0]           nonce_reg [NUM_CORES];
  logic [31:0]           h0_reg    [NUM_CORES];

  logic                  disp_ok;
  logic [CW-1:0]         disp_idx;
  logic                  grant_ok;
  logic [CW-1:0]         grant_idx;

  always_comb begin
    disp_ok  = 1'b0;
    disp_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (!core_busy[i]) begin
        disp_ok  = 1'b1;
        disp_idx = CW'(i);
      end
    end
    if (next_nonce >= TOTAL) disp_ok = 1'b0;
  end

`ifdef NONCE_SCHED_RR_EN
  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] cand;

  // Walk backwards from the farthest candidate so the one nearest rr_ptr wins.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      cand = CW'((int'(rr_ptr) + k) % NUM_CORES);
      if (pending[cand]) begin
        grant_ok  = 1'b1;
        grant_idx = cand;
      end
    end
  end
`else
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_ok  = 1'b1;
        grant_idx = CW'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      done           <= 1'b0;
      busy           <= 1'b0;
      core_start     <= '0;
      core_nonce     <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      next_nonce     <= '0;
      written_cnt    <= '0;
      core_busy      <= '0;
      pending        <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        nonce_reg[i] <= '0;
        h0_reg[i]    <= '0;
      end
`ifdef NONCE_SCHED_RR_EN
      rr_ptr         <= '0;
`endif
    end else begin
      core_start <= '0;
      mem_we     <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            state       <= RUN;
            next_nonce  <= '0;
            written_cnt <= '0;
            core_busy   <= '0;
            pending     <= '0;
          end
        end
        RUN: begin
          busy <= 1'b1;
          if (written_cnt == TOTAL) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            if (disp_ok) begin
              core_start[disp_idx] <= 1'b1;
              core_nonce           <= {16'h0000, next_nonce};
              nonce_reg[disp_idx]  <= next_nonce;
              core_busy[disp_idx]  <= 1'b1;
              next_nonce           <= next_nonce + 16'd1;
            end
            // Results from cores we never dispatched are dropped here.
            for (int i = 0; i < NUM_CORES; i++) begin
              if (core_done[i] && core_busy[i]) begin
                pending[i] <= 1'b1;
                h0_reg[i]  <= core_h0[32*i +: 32];
              end
            end
            if (grant_ok) begin
              mem_we               <= 1'b1;
              mem_addr             <= output_addr + nonce_reg[grant_idx];
              mem_write_data       <= h0_reg[grant_idx];
              pending[grant_idx]   <= 1'b0;
              core_busy[grant_idx] <= 1'b0;
              written_cnt          <= written_cnt + 16'd1;
`ifdef NONCE_SCHED_RR_EN
              rr_ptr <= (grant_idx == CW'(NUM_CORES - 1)) ? '0 : grant_idx + CW'(1);
`endif
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Directed bench for sha_nonce_scheduler: hand sequences for dispatch/arbitration/reset corners and a job table.
module tb_sha_nonce_scheduler;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [15:0]  output_addr;
  logic         done, busy;
  logic [3:0]   core_start;
  logic [31:0]  core_nonce;
  logic [3:0]   core_done = '0;
  logic [127:0] core_h0 = '0;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_write_data;

  logic         one_start;
  logic         one_done, one_busy;
  logic [3:0]   one_core_start;
  logic [31:0]  one_core_nonce;
  logic [3:0]   one_core_done;
  logic [127:0] one_core_h0;
  logic         one_mem_we;
  logic [15:0]  one_mem_addr;
  logic [31:0]  one_mem_data;

  int total = 0;
  int bad   = 0;

  bit          auto_en = 1'b0;
  logic [31:0] h0_base = '0;
  logic [3:0]  man_done = '0;
  logic [31:0] man_h0 [4] = '{default: '0};

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t wlog[$];
  int  done_cnt = 0;

  typedef struct {
    logic [15:0] base;
    logic [31:0] h0b;
    int          exp_writes;
    int          exp_dones;
  } job_t;
  job_t jobs [3];

  initial forever #5 clk = ~clk;

  sha_nonce_scheduler #(.NUM_CORES(4), .NONCE_TOTAL(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .output_addr(output_addr),
    .done(done), .busy(busy), .core_start(core_start), .core_nonce(core_nonce),
    .core_done(core_done), .core_h0(core_h0), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data)
  );

  sha_nonce_scheduler #(.NUM_CORES(4), .NONCE_TOTAL(1)) u_one (
    .clk(clk), .reset_n(reset_n), .start(one_start), .output_addr(16'h2222),
    .done(one_done), .busy(one_busy), .core_start(one_core_start), .core_nonce(one_core_nonce),
    .core_done(one_core_done), .core_h0(one_core_h0), .mem_we(one_mem_we),
    .mem_addr(one_mem_addr), .mem_write_data(one_mem_data)
  );

  // Core model: auto mode answers 10 cycles after core_start with h0_base+nonce; man_done injects pulses.
  initial begin
    bit          act [4];
    int          tmr [4];
    logic [31:0] mnonce [4];
    logic [31:0] ah0 [4];
    logic [3:0]  ad;
    for (int i = 0; i < 4; i++) begin
      act[i] = 1'b0; tmr[i] = 0; mnonce[i] = '0; ah0[i] = '0;
    end
    forever begin
      @(negedge clk);
      #1;
      ad = '0;
      for (int i = 0; i < 4; i++) begin
        if (!auto_en || !reset_n) act[i] = 1'b0;
        else if (act[i]) begin
          if (tmr[i] == 0) begin
            ad[i]  = 1'b1;
            ah0[i] = h0_base + mnonce[i];
            act[i] = 1'b0;
          end else tmr[i]--;
        end
        if (auto_en && reset_n && core_start[i]) begin
          act[i] = 1'b1; tmr[i] = 9; mnonce[i] = core_nonce;
        end
        core_done[i]        = ad[i] | man_done[i];
        core_h0[32*i +: 32] = man_done[i] ? man_h0[i] : ah0[i];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mem_we) wlog.push_back('{a: mem_addr, d: mem_write_data});
    if (done) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_core_start"}, 32'(core_start), 0);
    chk({tag, "_core_nonce"}, core_nonce, 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_data"}, mem_write_data, 0);
  endtask

  // One core finishes alone: write after two edges, then that core is re-dispatched.
  task automatic single_done(input int idx, input logic [31:0] h0, input logic [15:0] exp_addr,
                             input logic [31:0] exp_nonce);
    @(negedge clk);
    man_h0[idx] = h0; man_done = 4'(1 << idx);
    @(negedge clk);
    man_done = '0;
    chk("single_we_early", 32'(mem_we), 0);
    @(negedge clk);
    chk("single_we", 32'(mem_we), 1);
    chk("single_addr", 32'(mem_addr), 32'(exp_addr));
    chk("single_data", mem_write_data, h0);
    @(negedge clk);
    chk("single_we_after", 32'(mem_we), 0);
    chk("redispatch_start", 32'(core_start), 32'(1 << idx));
    chk("redispatch_nonce", core_nonce, exp_nonce);
  endtask

  task automatic run_job(input job_t j, input int id);
    int   li, d0;
    bit   seen;
    logic [15:0] a;
    logic [31:0] mem [logic [15:0]];
    li = wlog.size(); d0 = done_cnt;
    auto_en = 1'b1; h0_base = j.h0b; output_addr = j.base;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk($sformatf("job%0d_done_seen", id), 32'(seen), 1);
    chk($sformatf("job%0d_we_in_finish", id), 32'(mem_we), 0);
    chk($sformatf("job%0d_busy_in_finish", id), 32'(busy), 32'(seen));
    @(negedge clk);
    chk($sformatf("job%0d_busy_after", id), 32'(busy), 0);
    chk($sformatf("job%0d_done_after", id), 32'(done), 0);
    chk($sformatf("job%0d_writes", id), 32'(wlog.size() - li), 32'(j.exp_writes));
    chk($sformatf("job%0d_dones", id), 32'(done_cnt - d0), 32'(j.exp_dones));
    for (int k = li; k < wlog.size(); k++) mem[wlog[k].a] = wlog[k].d;
    for (int n = 0; n < 16; n++) begin
      a = j.base + 16'(n);
      chk($sformatf("job%0d_mem[%h]", id, a), mem.exists(a) ? mem[a] : 32'hxxxxxxxx, j.h0b + 32'(n));
    end
  endtask

  initial begin
    logic [15:0] exp_a [4];
    logic [31:0] exp_d [4];
    jobs[0] = '{base: 16'h00B0, h0b: 32'hA500_0000, exp_writes: 16, exp_dones: 1};
    jobs[1] = '{base: 16'hFFFE, h0b: 32'h5A5A_0000, exp_writes: 16, exp_dones: 1};
    jobs[2] = '{base: 16'h0000, h0b: 32'h0000_1000, exp_writes: 16, exp_dones: 1};

    reset_n = 1'b0; start = 1'b0; output_addr = 16'h0100;
    one_start = 1'b0; one_core_done = '0; one_core_h0 = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;

    // Dispatch order, with a spurious done on an idle core and a start during RUN.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_accept", 32'(busy), 0);
    chk("cs_after_accept", 32'(core_start), 0);
    man_h0[3] = 32'hDEAD_BEEF; man_done = 4'b1000; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      man_done = '0; start = 1'b0;
      chk("disp_busy", 32'(busy), 1);
      chk($sformatf("disp_start%0d", i), 32'(core_start), 32'(1 << i));
      chk($sformatf("disp_nonce%0d", i), core_nonce, 32'(i));
      chk("disp_no_we", 32'(mem_we), 0);
    end
    @(negedge clk);
    chk("all_busy_no_start", 32'(core_start), 0);
    chk("spurious_no_we", 32'(mem_we), 0);

    single_done(0, 32'hC0DE_0000, 16'h0100, 32'd4);
    single_done(1, 32'hC0DE_0001, 16'h0101, 32'd5);

    // Simultaneous completion: cores hold nonces 4,5,2,3.
`ifdef NONCE_SCHED_RR_EN
    exp_a = '{16'h0102, 16'h0103, 16'h0104, 16'h0105};
    exp_d = '{32'hC0DE_0012, 32'hC0DE_0013, 32'hC0DE_0010, 32'hC0DE_0011};
`else
    exp_a = '{16'h0104, 16'h0105, 16'h0102, 16'h0103};
    exp_d = '{32'hC0DE_0010, 32'hC0DE_0011, 32'hC0DE_0012, 32'hC0DE_0013};
`endif
    @(negedge clk);
    for (int i = 0; i < 4; i++) man_h0[i] = 32'hC0DE_0010 + 32'(i);
    man_done = 4'hF;
    @(negedge clk);
    man_done = '0;
    chk("simul_we_early", 32'(mem_we), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("simul_we%0d", i), 32'(mem_we), 1);
      chk($sformatf("simul_addr%0d", i), 32'(mem_addr), 32'(exp_a[i]));
      chk($sformatf("simul_data%0d", i), mem_write_data, exp_d[i]);
    end

    // Mid-job reset, then late core results must be ignored.
    @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); man_done = 4'hF;
    @(negedge clk); man_done = '0;
    repeat (2) @(negedge clk);
    chk("late_done_no_we", 32'(mem_we), 0);
    chk("late_done_idle", 32'(busy), 0);

    // NONCE_TOTAL=1 instance: only core 0 runs, one write, then done.
    @(negedge clk); one_start = 1'b1;
    @(negedge clk); one_start = 1'b0;
    @(negedge clk);
    chk("one_start", 32'(one_core_start), 1);
    chk("one_nonce", one_core_nonce, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("one_no_more_disp", 32'(one_core_start), 0);
    end
    one_core_h0[31:0] = 32'h1234_5678; one_core_done = 4'b0001;
    @(negedge clk); one_core_done = '0;
    chk("one_we_early", 32'(one_mem_we), 0);
    @(negedge clk);
    chk("one_we", 32'(one_mem_we), 1);
    chk("one_addr", 32'(one_mem_addr), 32'h2222);
    chk("one_data", one_mem_data, 32'h1234_5678);
    chk("one_done_early", 32'(one_done), 0);
    @(negedge clk);
    chk("one_done", 32'(one_done), 1);
    chk("one_we_finish", 32'(one_mem_we), 0);
    chk("one_busy_finish", 32'(one_busy), 1);
    @(negedge clk);
    chk("one_done_end", 32'(one_done), 0);
    chk("one_busy_end", 32'(one_busy), 0);

    for (int j = 0; j < 3; j++) run_job(jobs[j], j);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
